fpu_req_scheduler: RTL and testbench

Front-end issue/response block for the `fpu` core. Accepts floating-point operation requests over a valid/ready handshake and drives the FPU operand/opcode inputs. Tracks in-flight operations through the FPU's fixed pipeline latency, then captures the result and eight exception flags into an in-order response FIFO with tag and backpressure. This block replaces direct testcase driving of the FPU interface and lets any requester use the FPU without knowing its latency.

---
 rtl/fpu_req_scheduler_if.sv | 28 ++
 rtl/fpu_req_scheduler.sv | 127 ++++++++++++
 tb/tb_fpu_req_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_req_scheduler_if.sv
// Request/response handshake bundle between a requester and fpu_req_scheduler.
// The requester takes the master modport; the scheduler takes the slave modport.
interface fpu_req_scheduler_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic [1:0]       req_rmode;
    logic [2:0]       req_op;
    logic [31:0]      req_opa;
    logic [31:0]      req_opb;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_data;
    logic [7:0]       rsp_flags;

    modport master (
        output req_valid, req_tag, req_rmode, req_op, req_opa, req_opb, rsp_ready,
        input  req_ready, rsp_valid, rsp_tag, rsp_data, rsp_flags
    );

    modport slave (
        input  req_valid, req_tag, req_rmode, req_op, req_opa, req_opb, rsp_ready,
        output req_ready, rsp_valid, rsp_tag, rsp_data, rsp_flags
    );
endinterface

// File: rtl/fpu_req_scheduler.sv
// Issue/response front end for the fixed-latency FPU: registers operands, tracks
// in-flight tags through the pipeline and returns results in order via a credit-guarded FIFO.
module fpu_req_scheduler #(
    parameter int  LATENCY = 4,
    parameter int  DEPTH   = 8,
    parameter int  TAG_W   = 4,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_req_scheduler_if.slave   io_bus,
    output logic [1:0]           o_fpu_rmode,
    output logic [2:0]           o_fpu_op,
    output logic [31:0]          o_fpu_opa,
    output logic [31:0]          o_fpu_opb,
    input  logic [31:0]          i_fpu_out,
    input  logic [7:0]           i_fpu_flags,
    output logic [CNT_W-1:0]     o_outstanding
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = TAG_W + 32 + 8;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic                 w_issue;
    logic                 w_pop;
    logic                 w_push;
    logic [LATENCY-1:0]   r_pipe_vld;
    logic [TAG_W-1:0]     r_pipe_tag [LATENCY];
    logic [ENT_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     r_outstanding;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_ONE;
    endfunction

    // Credits cover both in-flight ops and buffered results, so a push never meets a full FIFO.
    assign io_bus.req_ready = (r_outstanding < DEPTH_C);
    assign w_issue          = io_bus.req_valid && io_bus.req_ready;
    assign io_bus.rsp_valid = (r_count != {CNT_W{1'b0}});
    assign w_pop            = io_bus.rsp_valid && io_bus.rsp_ready;
    assign w_push           = r_pipe_vld[LATENCY-1];
    assign {io_bus.rsp_tag, io_bus.rsp_data, io_bus.rsp_flags} = r_mem[r_rptr];
    assign o_outstanding    = r_outstanding;

    // Operand/opcode registers feeding the FPU; they hold between issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_fpu_rmode <= 2'd0;
            o_fpu_op    <= 3'd0;
            o_fpu_opa   <= 32'd0;
            o_fpu_opb   <= 32'd0;
        end else if (w_issue) begin
            o_fpu_rmode <= io_bus.req_rmode;
            o_fpu_op    <= io_bus.req_op;
            o_fpu_opa   <= io_bus.req_opa;
            o_fpu_opb   <= io_bus.req_opb;
        end
    end

    // Tag pipe mirroring the FPU depth; it never stalls because the FPU cannot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe_tag[i] <= {TAG_W{1'b0}};
            end
        end else begin
            r_pipe_vld[0] <= w_issue;
            r_pipe_tag[0] <= io_bus.req_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
        end
    end

    // Response storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {ENT_W{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= {r_pipe_tag[LATENCY-1], i_fpu_out, i_fpu_flags};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Outstanding credit counter: issued but not yet popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= {CNT_W{1'b0}};
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_req_scheduler.sv
// Directed bench for fpu_req_scheduler: a behavioural FPU drives the result port and a
// queue-based response model is compared against the DUT at every falling edge.
module tb_fpu_req_scheduler;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;
    localparam int TAG_W   = 4;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       fpu_rmode;
    logic [2:0]       fpu_op;
    logic [31:0]      fpu_opa;
    logic [31:0]      fpu_opb;
    logic [31:0]      fpu_out;
    logic [7:0]       fpu_flags;
    logic [CNT_W-1:0] outstanding;
    int               n_tests = 0;
    int               n_fail  = 0;

    fpu_req_scheduler_if #(.TAG_W(TAG_W)) bus ();

    fpu_req_scheduler #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io_bus        (bus),
        .o_fpu_rmode   (fpu_rmode),
        .o_fpu_op      (fpu_op),
        .o_fpu_opa     (fpu_opa),
        .o_fpu_opb     (fpu_opb),
        .i_fpu_out     (fpu_out),
        .i_fpu_flags   (fpu_flags),
        .o_outstanding (outstanding)
    );

    always #5 clk = ~clk;

    // Known IEEE cases are exact; other encodings give a deterministic scrambled result.
    function automatic logic [39:0] fpu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 3'd3 && b[30:0] == 31'd0 && a[30:0] != 31'd0)
            return {a[31] ^ b[31], 8'hFF, 23'd0, 8'h81};
        if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000)
            return {32'h40400000, 8'h00};
        return {a ^ {b[15:0], b[31:16]} ^ {29'd0, op}, a[7:0] ^ b[7:0]};
    endfunction

    // Behavioural FPU: registered operands plus LATENCY-1 internal stages, never reset.
    logic [39:0] fpu_stg [LATENCY-1] = '{default: 40'd0};
    always @(posedge clk) begin
        fpu_stg[0] <= fpu_fn(fpu_op, fpu_opa, fpu_opb);
        for (int i = 1; i < LATENCY - 1; i++) fpu_stg[i] <= fpu_stg[i-1];
    end
    assign {fpu_out, fpu_flags} = fpu_stg[LATENCY-2];

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic [7:0]       flags;
        int               due;
    } ent_t;

    ent_t        infl[$];
    ent_t        rspq[$];
    int          cyc = 0;
    logic [2:0]  m_op  = 3'd0;
    logic [31:0] m_opa = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        infl.delete();
        rspq.delete();
        m_op  = 3'd0;
        m_opa = 32'd0;
    endtask

    // One rising edge of the spec-level model, using inputs that were stable across that edge.
    task automatic model_edge();
        logic issue;
        ent_t e;
        issue = bus.req_valid && ((infl.size() + rspq.size()) < DEPTH);
        if (rspq.size() > 0 && bus.rsp_ready) void'(rspq.pop_front());
        while (infl.size() > 0 && infl[0].due == cyc) rspq.push_back(infl.pop_front());
        if (issue) begin
            e.tag = bus.req_tag;
            {e.data, e.flags} = fpu_fn(bus.req_op, bus.req_opa, bus.req_opb);
            e.due = cyc + LATENCY;
            infl.push_back(e);
            m_op  = bus.req_op;
            m_opa = bus.req_opa;
        end
        cyc++;
    endtask

    task automatic compare();
        int n;
        n = infl.size() + rspq.size();
        check("req_ready", 32'(bus.req_ready), 32'(n < DEPTH));
        check("outstanding", 32'(outstanding), 32'(n));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(rspq.size() != 0));
        check("fpu_op", 32'(fpu_op), 32'(m_op));
        check("fpu_opa", fpu_opa, m_opa);
        if (rspq.size() != 0) begin
            check("rsp_tag", 32'(bus.rsp_tag), 32'(rspq[0].tag));
            check("rsp_data", bus.rsp_data, rspq[0].data);
            check("rsp_flags", 32'(bus.rsp_flags), 32'(rspq[0].flags));
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst_n) begin
            model_edge();
            compare();
        end
    endtask

    task automatic drive_req(input logic [TAG_W-1:0] tag, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_tag   = tag;
        bus.req_rmode = 2'd0;
        bus.req_op    = op;
        bus.req_opa   = a;
        bus.req_opb   = b;
    endtask

    task automatic wait_rsp(input string name, output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_timeout"}, 32'(bus.rsp_valid), 32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int lat;
        int nseen;
        bus.req_valid = 1'b0;
        bus.req_tag   = '0;
        bus.req_rmode = 2'd0;
        bus.req_op    = 3'd0;
        bus.req_opa   = 32'd0;
        bus.req_opb   = 32'd0;
        bus.rsp_ready = 1'b0;
        model_clear();

        // Reset held for three cycles under random inputs.
        for (int i = 0; i < 3; i++) begin
            drive_req(4'($urandom), 3'($urandom), $urandom, $urandom);
            bus.req_valid = 1'($urandom);
            bus.rsp_ready = 1'($urandom);
            @(negedge clk);
        end
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_fpu_opa", fpu_opa, 32'd0);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b1;
        step();

        // Single add: 1.0 + 2.0.
        drive_req(4'd3, 3'd0, 32'h3F800000, 32'h40000000);
        bus.rsp_ready = 1'b1;
        step();
        check("add_fpu_opa", fpu_opa, 32'h3F800000);
        bus.req_valid = 1'b0;
        wait_rsp("add", lat);
        check("add_latency", 32'(lat), 32'd5);
        check("add_data", bus.rsp_data, 32'h40400000);
        check("add_tag", 32'(bus.rsp_tag), 32'd3);
        check("add_flags", 32'(bus.rsp_flags), 32'd0);
        repeat (2) step();

        // Fill under backpressure, then drain in order while a 9th request waits.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_req(4'(i), 3'd0, 32'h1000 + 32'(i), 32'h00030000 * 32'(i + 1));
            step();
        end
        drive_req(4'd8, 3'd1, 32'hABCD0000, 32'h00001234);
        check("fill_req_ready", 32'(bus.req_ready), 32'd0);
        check("fill_outstanding", 32'(outstanding), 32'd8);
        repeat (6) step();
        check("fill_stall_outstanding", 32'(outstanding), 32'd8);
        bus.rsp_ready = 1'b1;
        nseen = 0;
        for (int c = 0; c < 40 && nseen < 9; c++) begin
            if (c == 1) begin
                check("first_pop_outstanding", 32'(outstanding), 32'd7);
                check("first_pop_req_ready", 32'(bus.req_ready), 32'd1);
            end
            if (c == 2) bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                check("drain_order", 32'(bus.rsp_tag), 32'(nseen));
                nseen++;
            end
            step();
        end
        check("drain_count", 32'(nseen), 32'd9);
        repeat (2) step();

        // Full FIFO: pop-only edge, then simultaneous issue and pop.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_req(4'(i + 8), 3'd2, 32'h5555_0000 + 32'(i), 32'h0000_7777);
            step();
        end
        bus.req_valid = 1'b0;
        repeat (6) step();
        drive_req(4'd5, 3'd0, 32'h1234_5678, 32'h0F0F_0F0F);
        bus.rsp_ready = 1'b1;
        check("full_req_ready", 32'(bus.req_ready), 32'd0);
        step();
        check("full_pop_outstanding", 32'(outstanding), 32'd7);
        check("full_pop_req_ready", 32'(bus.req_ready), 32'd1);
        step();
        check("full_issue_pop_outstanding", 32'(outstanding), 32'd7);
        bus.req_valid = 1'b0;
        for (int c = 0; c < 40 && (outstanding != 0 || bus.rsp_valid); c++) step();
        check("full_drained", 32'(outstanding), 32'd0);

        // Divide by zero: 1.0 / 0.0.
        drive_req(4'd10, 3'd3, 32'h3F800000, 32'h00000000);
        step();
        bus.req_valid = 1'b0;
        wait_rsp("div", lat);
        check("div_data", bus.rsp_data, 32'h7F800000);
        check("div_flag_dbz", 32'(bus.rsp_flags[7]), 32'd1);
        check("div_flag_inf", 32'(bus.rsp_flags[0]), 32'd1);
        check("div_tag", 32'(bus.rsp_tag), 32'd10);
        repeat (2) step();

        // Reset with three ops in flight and two buffered.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_req(4'(i + 1), 3'd0, 32'h2000 + 32'(i), 32'h0004_0000);
            step();
        end
        bus.req_valid = 1'b0;
        step();
        check("pre_rst_outstanding", 32'(outstanding), 32'd5);
        check("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("async_rst_outstanding", 32'(outstanding), 32'd0);
        check("async_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("async_rst_rsp_data", bus.rsp_data, 32'd0);
        check("async_rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        check("async_rst_fpu_opa", fpu_opa, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check("post_rst_quiet", 32'(bus.rsp_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
